// File: rtl/conv5x5_mac.sv
// conv5x5_mac: applies L stored 5x5 signed filters to one 5x5 signed pixel window.
// Filters are loaded one per wl_valid beat; after the L-th beat the block accepts
// a window and issues one filter per cycle into a two-stage multiply / add-tree pipeline.
// Latency: the result for filter k appears in cycle T+3+k after the window is accepted in cycle T.
// Backpressure: win_ready is asserted only in READY with all filters loaded. There is no output backpressure.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   wl_valid, weight_bank    filter load beat (25 x w-bit signed weights)
//   win_valid, window, win_ready    window handshake (25 x w-bit signed pixels)
//   wl_done             pulse when the L-th filter has been captured
//   out_valid, out_filt, out_data, done    one result per filter; done marks filter L-1
// Optional macro CONV5X5_MAC_RELU_EN: when defined, stage 2 clamps negative sums to 0.
// Latency is the same whether or not the macro is defined.
// L must be in the range 2..8, because out_filt is 3 bits wide.
module conv5x5_mac #(
    parameter int w = 8,
    parameter int L = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wl_valid,
    input  logic [25*w-1:0]       weight_bank,
    input  logic                  win_valid,
    input  logic [25*w-1:0]       window,
    output logic                  win_ready,
    output logic                  wl_done,
    output logic                  out_valid,
    output logic [2:0]            out_filt,
    output logic signed [2*w+4:0] out_data,
    output logic                  done
);

    localparam int OW = 2*w + 5;   // a 25-term sum of w x w products fits without wrap
    localparam int CW = 3;

    typedef enum logic [1:0] {IDLE, LOAD, READY, MAC} state_t;

    state_t          state;
    logic [CW-1:0]   ld_idx;
    logic [CW-1:0]   mac_idx;
    logic            loaded;
    logic [25*w-1:0] win_q;
    logic [25*w-1:0] filt_mem [L];

    logic accept;
    logic issue;
    logic issue_last;

    assign accept     = (state == READY) && win_valid && win_ready;
    assign issue      = (state == MAC);
    assign issue_last = issue && (mac_idx == CW'(L-1));

    // Control FSM. The state, the counters and the handshake outputs are all registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ld_idx    <= '0;
            mac_idx   <= '0;
            loaded    <= 1'b0;
            win_ready <= 1'b0;
            wl_done   <= 1'b0;
        end else begin
            wl_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (wl_valid) begin
                        state     <= LOAD;
                        ld_idx    <= CW'(1);
                        loaded    <= 1'b0;
                        win_ready <= 1'b0;
                    end
                end
                LOAD: begin
                    if (wl_valid) begin
                        if (ld_idx == CW'(L-1)) begin
                            state     <= READY;
                            ld_idx    <= '0;
                            loaded    <= 1'b1;
                            wl_done   <= 1'b1;
                            win_ready <= 1'b1;
                        end else begin
                            ld_idx <= ld_idx + CW'(1);
                        end
                    end
                end
                READY: begin
                    // If a window and a load beat arrive in the same cycle, the window wins.
                    if (accept) begin
                        state     <= MAC;
                        mac_idx   <= '0;
                        win_ready <= 1'b0;
                    end else if (wl_valid) begin
                        // A reload invalidates the filter set until its last beat arrives.
                        state     <= LOAD;
                        ld_idx    <= CW'(1);
                        loaded    <= 1'b0;
                        win_ready <= 1'b0;
                    end
                end
                MAC: begin
                    // Load beats and windows are ignored while filters are being issued.
                    if (mac_idx == CW'(L-1)) begin
                        state     <= READY;
                        mac_idx   <= '0;
                        win_ready <= loaded;
                    end else begin
                        mac_idx <= mac_idx + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Filter and window storage. This storage is not reset.
    // Until a full reload completes, loaded stays low, so stale contents are never used.
    always_ff @(posedge clk) begin
        if (wl_valid && (state == IDLE || (state == READY && !accept)))
            filt_mem[0] <= weight_bank;
        else if (wl_valid && state == LOAD)
            filt_mem[ld_idx] <= weight_bank;
        if (accept)
            win_q <= window;
    end

    // Stage 1: 25 signed w x w products for the filter selected by mac_idx.
    logic signed [2*w-1:0] prod_c [25];
    logic signed [2*w-1:0] s1_prod [25];
    logic                  s1_vld;
    logic [CW-1:0]         s1_filt;
    logic                  s1_last;

    always_comb begin
        for (int i = 0; i < 25; i++)
            prod_c[i] = $signed(win_q[w*i +: w]) * $signed(filt_mem[mac_idx][w*i +: w]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s1_filt <= '0;
            s1_last <= 1'b0;
        end else begin
            s1_vld  <= issue;
            s1_filt <= issue ? mac_idx : '0;
            s1_last <= issue_last;
        end
    end

    always_ff @(posedge clk) begin
        if (issue)
            s1_prod <= prod_c;
    end

    // Stage 2: sign-extended 25-term sum, with an optional ReLU before the output register.
    logic signed [OW-1:0] sum_c;
    logic signed [OW-1:0] sum_r;

    always_comb begin
        sum_c = '0;
        for (int i = 0; i < 25; i++)
            sum_c = sum_c + OW'(s1_prod[i]);
`ifdef CONV5X5_MAC_RELU_EN
        sum_r = (sum_c < 0) ? '0 : sum_c;
`else
        sum_r = sum_c;
`endif
    end

    // While out_valid is low, out_data and out_filt are held at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_filt  <= '0;
            out_data  <= '0;
            done      <= 1'b0;
        end else begin
            out_valid <= s1_vld;
            out_filt  <= s1_vld ? s1_filt : '0;
            out_data  <= s1_vld ? sum_r : '0;
            done      <= s1_last;
        end
    end

endmodule

// File: tb/tb_conv5x5_mac.sv
// tb_conv5x5_mac: drives conv5x5_mac with directed and random filter and window sets.
// Every result is compared with a dot product computed in plain integer arithmetic.
// Inputs change 1 time unit after the rising edge, and outputs are sampled at that same point.
module tb_conv5x5_mac;

    localparam int W  = 8;
    localparam int NL = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              wl_valid;
    logic [25*W-1:0]   weight_bank;
    logic              win_valid;
    logic [25*W-1:0]   window;
    logic              win_ready;
    logic              wl_done;
    logic              out_valid;
    logic [2:0]        out_filt;
    logic signed [2*W+4:0] out_data;
    logic              done;

    conv5x5_mac #(.w(W), .L(NL)) dut (
        .clk(clk), .rst(rst),
        .wl_valid(wl_valid), .weight_bank(weight_bank),
        .win_valid(win_valid), .window(window), .win_ready(win_ready),
        .wl_done(wl_done), .out_valid(out_valid), .out_filt(out_filt),
        .out_data(out_data), .done(done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int wt  [NL][25];
    int pix [25];

    task automatic check(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [25*W-1:0] pack_filt(input int k);
        logic [25*W-1:0] v;
        int t;
        for (int i = 0; i < 25; i++) begin
            t = wt[k][i];
            v[W*i +: W] = t[W-1:0];
        end
        return v;
    endfunction

    function automatic logic [25*W-1:0] pack_pix();
        logic [25*W-1:0] v;
        int t;
        for (int i = 0; i < 25; i++) begin
            t = pix[i];
            v[W*i +: W] = t[W-1:0];
        end
        return v;
    endfunction

    // Reference model: the plain integer dot product, with an optional clamp at zero.
    function automatic longint ref_dot(input int k);
        longint s = 0;
        for (int i = 0; i < 25; i++)
            s += longint'(wt[k][i]) * longint'(pix[i]);
`ifdef CONV5X5_MAC_RELU_EN
        if (s < 0) s = 0;
`endif
        return s;
    endfunction

    task automatic set_filters(input int mode);
        for (int k = 0; k < NL; k++)
            for (int i = 0; i < 25; i++)
                case (mode)
                    0: wt[k][i] = k + 1;
                    1: wt[k][i] = -1;
                    2: wt[k][i] = -128;
                    default: wt[k][i] = int'($urandom_range(0, 255)) - 128;
                endcase
    endtask

    task automatic set_pixels(input int mode);
        for (int i = 0; i < 25; i++)
            case (mode)
                0: pix[i] = 1;
                1: pix[i] = 3;
                2: pix[i] = -128;
                default: pix[i] = int'($urandom_range(0, 255)) - 128;
            endcase
    endtask

    // Sends NL load beats, with `gap` idle cycles after each one.
    // wl_done and win_ready must rise only after the final beat.
    task automatic load_filters(input int gap);
        for (int k = 0; k < NL; k++) begin
            wl_valid    = 1'b1;
            weight_bank = pack_filt(k);
            step();
            wl_valid    = 1'b0;
            weight_bank = '0;
            check("wl_done_beat", wl_done, (k == NL-1));
            check("win_ready_beat", win_ready, (k == NL-1));
            for (int g = 0; g < gap; g++) begin
                step();
                check("wl_done_gap", wl_done, 0);
            end
        end
    endtask

    // Presents one window in cycle T, then checks every output in cycles T+1 through T+NL+5.
    // When hold=1, win_valid stays high through the MAC cycles, and those extra windows must be ignored.
    task automatic run_window(input int hold);
        win_valid = 1'b1;
        window    = pack_pix();
        check("win_ready_T", win_ready, 1);
        step();
        for (int c = 1; c <= NL + 5; c++) begin
            win_valid = (hold != 0) && (c <= NL);
            check("out_valid", out_valid, (c >= 3 && c <= NL + 2));
            check("out_filt", out_filt, (c >= 3 && c <= NL + 2) ? c - 3 : 0);
            check("out_data", $signed(out_data), (c >= 3 && c <= NL + 2) ? ref_dot(c - 3) : 0);
            check("done", done, (c == NL + 2));
            check("win_ready_mac", win_ready, (c >= NL + 1));
            step();
        end
        win_valid = 1'b0;
    endtask

    // Holds win_valid high while no complete filter set is loaded. Nothing may be accepted.
    task automatic early_window(input int cycles);
        win_valid = 1'b1;
        window    = pack_pix();
        for (int c = 0; c < cycles; c++) begin
            check("win_ready_unloaded", win_ready, 0);
            check("out_valid_unloaded", out_valid, 0);
            step();
        end
        win_valid = 1'b0;
        check("out_valid_after_early", out_valid, 0);
    endtask

    initial begin
        rst = 1'b1; wl_valid = 1'b0; weight_bank = '0; win_valid = 1'b0; window = '0;
        step();
        step();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", $signed(out_data), 0);
        check("rst_out_filt", out_filt, 0);
        check("rst_done", done, 0);
        check("rst_wl_done", wl_done, 0);
        check("rst_win_ready", win_ready, 0);
        rst = 1'b0;
        step();

        // A window presented before any filters are loaded must be ignored.
        set_pixels(0);
        early_window(4);

        // Weight k+1 for filter k with all-ones pixels gives 25, 50, ..., 150.
        set_filters(0);
        load_filters(0);
        run_window(0);

        // A reload from READY with gaps must give the same results.
        load_filters(2);
        run_window(0);

        // Negative sum: -75 normally, 0 with the clamp enabled.
        set_filters(1);
        set_pixels(1);
        load_filters(0);
        run_window(0);

        // Extreme magnitudes: 25 * 16384 = 409600 must not wrap.
        set_filters(2);
        set_pixels(2);
        load_filters(1);
        run_window(1);

        // Random filters and windows, with random gaps between load beats.
        for (int r = 0; r < 4; r++) begin
            set_filters(3);
            load_filters(int'($urandom_range(0, 2)));
            for (int n = 0; n < 2; n++) begin
                set_pixels(3);
                run_window(int'($urandom_range(0, 1)));
            end
        end

        // Reset in cycle T+4 of a MAC operation aborts it.
        set_filters(3);
        set_pixels(3);
        load_filters(0);
        win_valid = 1'b1;
        window    = pack_pix();
        check("abort_win_ready_T", win_ready, 1);
        step();
        win_valid = 1'b0;
        step();
        step();
        step();
        check("abort_out_T4", $signed(out_data), ref_dot(1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int c = 0; c < NL + 2; c++) begin
            check("abort_out_valid", out_valid, 0);
            check("abort_out_data", $signed(out_data), 0);
            check("abort_done", done, 0);
            check("abort_wl_done", wl_done, 0);
            step();
        end
        early_window(3);
        set_filters(3);
        load_filters(0);
        set_pixels(3);
        run_window(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog: stops a runaway simulation.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
